// File: rtl/conv3x3_engine.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_engine
// Purpose  : 3-stage pipelined 3x3 convolution with loadable signed kernel,
//            rounding shift, abs/clamp modes and valid/ready back-pressure.
// Revision : 1.0
// ============================================================================
module conv3x3_engine #(
   parameter int PIX_W  = 8,
   parameter int COEF_W = 8,
   parameter int ACC_W  = PIX_W + COEF_W + 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [9*PIX_W-1:0]    i_pixel_data,
   input  logic                  i_pixel_data_valid,
   output logic                  o_pixel_ready,
   input  logic [1:0]            i_mode,
   input  logic [3:0]            i_shift,
   input  logic                  i_coef_we,
   input  logic [3:0]            i_coef_addr,
   input  logic [COEF_W-1:0]     i_coef_data,
   output logic [PIX_W-1:0]      o_convolved_data,
   output logic                  o_convolved_data_valid,
   input  logic                  i_out_ready,
   output logic                  o_sat
);

   localparam int c_prod_w = PIX_W + 1 + COEF_W;
   localparam int c_norm_w = ACC_W + 2;
   localparam logic [1:0] c_mode_bypass = 2'b00;
   localparam logic [1:0] c_mode_abs    = 2'b10;
   localparam logic [1:0] c_mode_invert = 2'b11;
   localparam logic signed [c_norm_w-1:0] c_pix_max = c_norm_w'((1 << PIX_W) - 1);

   logic                       w_adv;
   logic signed [COEF_W-1:0]   r_coef [9];
   logic signed [c_prod_w-1:0] w_prod [9];

   logic                       r_s1_valid;
   logic signed [c_prod_w-1:0] r_s1_prod [9];
   logic [PIX_W-1:0]           r_s1_centre;
   logic [1:0]                 r_s1_mode;
   logic [3:0]                 r_s1_shift;

   logic signed [ACC_W-1:0]    w_sum;
   logic                       r_s2_valid;
   logic signed [ACC_W-1:0]    r_s2_sum;
   logic [PIX_W-1:0]           r_s2_centre;
   logic [1:0]                 r_s2_mode;
   logic [3:0]                 r_s2_shift;

   logic signed [c_norm_w-1:0] w_v;
   logic signed [c_norm_w-1:0] w_rnd;
   logic signed [c_norm_w-1:0] w_norm;
   logic [PIX_W-1:0]           w_res;
   logic                       w_sat;

   // Every stage moves together; the engine only stalls when the output is held.
   assign w_adv         = !o_convolved_data_valid || i_out_ready;
   assign o_pixel_ready = w_adv;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < 9; k++) begin
            r_coef[k] <= (k == 4) ? COEF_W'(1) : COEF_W'(0);
         end
      end else if (i_coef_we) begin
         for (int k = 0; k < 9; k++) begin
            if (i_coef_addr == 4'(k)) begin
               r_coef[k] <= i_coef_data;
            end
         end
      end
   end

   genvar gk;
   generate
      for (gk = 0; gk < 9; gk++) begin : g_prod
         logic signed [c_prod_w-1:0] w_pix_ext;
         logic signed [c_prod_w-1:0] w_coef_ext;
         assign w_pix_ext  = $signed({{(COEF_W+1){1'b0}}, i_pixel_data[gk*PIX_W +: PIX_W]});
         assign w_coef_ext = $signed({{(PIX_W+1){r_coef[gk][COEF_W-1]}}, r_coef[gk]});
         assign w_prod[gk] = w_pix_ext * w_coef_ext;
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_centre <= '0;
         r_s1_mode   <= '0;
         r_s1_shift  <= '0;
         for (int k = 0; k < 9; k++) begin
            r_s1_prod[k] <= '0;
         end
      end else if (w_adv) begin
         r_s1_valid <= i_pixel_data_valid;
         if (i_pixel_data_valid) begin
            r_s1_centre <= i_pixel_data[4*PIX_W +: PIX_W];
            r_s1_mode   <= i_mode;
            r_s1_shift  <= i_shift;
            for (int k = 0; k < 9; k++) begin
               r_s1_prod[k] <= w_prod[k];
            end
         end
      end
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < 9; k++) begin
         w_sum = w_sum + $signed({{(ACC_W-c_prod_w){r_s1_prod[k][c_prod_w-1]}}, r_s1_prod[k]});
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s2_valid  <= 1'b0;
         r_s2_sum    <= '0;
         r_s2_centre <= '0;
         r_s2_mode   <= '0;
         r_s2_shift  <= '0;
      end else if (w_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_sum    <= w_sum;
            r_s2_centre <= r_s1_centre;
            r_s2_mode   <= r_s1_mode;
            r_s2_shift  <= r_s1_shift;
         end
      end
   end

   // Two guard bits keep |sum| and the rounding add from overflowing.
   always_comb begin
      w_v = {{2{r_s2_sum[ACC_W-1]}}, r_s2_sum};
      if (r_s2_mode == c_mode_abs && w_v < 0) begin
         w_v = -w_v;
      end
      w_rnd  = (c_norm_w'(1) << r_s2_shift) >> 1;
      w_norm = (w_v + w_rnd) >>> r_s2_shift;
      w_res  = w_norm[PIX_W-1:0];
      w_sat  = 1'b0;
      if (w_norm < 0) begin
         w_res = '0;
         w_sat = 1'b1;
      end else if (w_norm > c_pix_max) begin
         w_res = '1;
         w_sat = 1'b1;
      end
      if (r_s2_mode == c_mode_bypass) begin
         w_res = r_s2_centre;
         w_sat = 1'b0;
      end else if (r_s2_mode == c_mode_invert) begin
         w_res = ~r_s2_centre;
         w_sat = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_convolved_data_valid <= 1'b0;
         o_convolved_data       <= '0;
         o_sat                  <= 1'b0;
      end else if (w_adv) begin
         o_convolved_data_valid <= r_s2_valid;
         if (r_s2_valid) begin
            o_convolved_data <= w_res;
            o_sat            <= w_sat;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_engine
// Purpose  : Randomised and directed checks of conv3x3_engine against a
//            queue-based arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_conv3x3_engine;

   localparam int PW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [9*PW-1:0] pix = '0;
   logic            pvalid = 1'b0;
   logic            pready;
   logic [1:0]      mode = 2'b01;
   logic [3:0]      shift = '0;
   logic            we = 1'b0;
   logic [3:0]      addr = '0;
   logic [7:0]      cdata = '0;
   logic [PW-1:0]   odata;
   logic            ovalid;
   logic            oready = 1'b1;
   logic            osat;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         m_coef [9];
   logic [PW:0] exp_q [$];
   int         acc_cyc_q [$];
   logic [PW:0] got_q [$];
   int         last_lat = 0;
   bit         prev_stall = 0;
   logic [PW:0] prev_out = '0;
   bit         saw_stall_ready_low = 0;

   conv3x3_engine #(.PIX_W(PW), .COEF_W(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_pixel_data(pix), .i_pixel_data_valid(pvalid), .o_pixel_ready(pready),
      .i_mode(mode), .i_shift(shift),
      .i_coef_we(we), .i_coef_addr(addr), .i_coef_data(cdata),
      .o_convolved_data(odata), .o_convolved_data_valid(ovalid),
      .i_out_ready(oready), .o_sat(osat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer convolution, rounding shift and clamp.
   function automatic logic [PW:0] model(input logic [9*PW-1:0] w, input logic [1:0] m,
                                         input logic [3:0] sh);
      int s, v, cen, maxv;
      maxv = (1 << PW) - 1;
      cen  = int'(w[4*PW +: PW]);
      if (m == 2'b00) return {1'b0, PW'(cen)};
      if (m == 2'b11) return {1'b0, PW'(maxv - cen)};
      s = 0;
      for (int k = 0; k < 9; k++) s += m_coef[k] * int'(w[k*PW +: PW]);
      v = (m == 2'b10 && s < 0) ? -s : s;
      if (sh > 0) v = (v + (1 << (sh - 1))) >>> sh;
      if (v < 0) return {1'b1, PW'(0)};
      if (v > maxv) return {1'b1, PW'(maxv)};
      return {1'b0, PW'(v)};
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         acc_cyc_q.delete();
         for (int k = 0; k < 9; k++) m_coef[k] = (k == 4) ? 1 : 0;
         prev_stall = 0;
      end else begin
         chk("ready_rule", pready, (!ovalid || oready));
         if (prev_stall) begin
            chk("stall_valid_held", ovalid, 1);
            chk("stall_out_held", {osat, odata}, prev_out);
         end
         if (ovalid && oready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got %0d expected none", odata);
            end else begin
               logic [PW:0] e;
               e = exp_q.pop_front();
               last_lat = cyc - acc_cyc_q.pop_front();
               chk("model_data", odata, e[PW-1:0]);
               chk("model_sat", osat, e[PW]);
            end
            got_q.push_back({osat, odata});
         end
         prev_stall = ovalid && !oready;
         prev_out   = {osat, odata};
         if (pvalid && pready) begin
            exp_q.push_back(model(pix, mode, shift));
            acc_cyc_q.push_back(cyc);
         end
         if (we && addr <= 4'd8) m_coef[addr] = int'($signed(cdata));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [9*PW-1:0] w, input logic [1:0] m, input logic [3:0] sh);
      bit acc = 0;
      int n = 0;
      pix = w; mode = m; shift = sh; pvalid = 1'b1;
      do begin
         @(negedge clk);
         acc = pready;
         tick();
         n++;
      end while (!acc && n < 100);
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got no ready expected ready within 100 cycles");
      end
      pvalid = 1'b0;
   endtask

   task automatic wait_got(input int n);
      int k = 0;
      while (got_q.size() < n && k < 100) begin
         tick();
         k++;
      end
      chk("output_count", got_q.size(), n);
   endtask

   task automatic coef_wr(input logic [3:0] a, input logic [7:0] d);
      we = 1'b1; addr = a; cdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic do_reset();
      pvalid = 1'b0;
      rst_n  = 1'b0;
      tick();
      tick();
      rst_n  = 1'b1;
   endtask

   function automatic logic [9*PW-1:0] win_all(input int v);
      logic [9*PW-1:0] w;
      for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(v);
      return w;
   endfunction

   function automatic logic [9*PW-1:0] win_cols(input int left, input int mid, input int right);
      logic [9*PW-1:0] w;
      for (int k = 0; k < 9; k++)
         w[k*PW +: PW] = PW'((k % 3 == 0) ? left : (k % 3 == 1) ? mid : right);
      return w;
   endfunction

   function automatic logic [9*PW-1:0] win_rand();
      logic [9*PW-1:0] w;
      for (int k = 0; k < 9; k++) begin
         case ($urandom % 8)
            0:       w[k*PW +: PW] = '0;
            1:       w[k*PW +: PW] = '1;
            default: w[k*PW +: PW] = PW'($urandom);
         endcase
      end
      return w;
   endfunction

   initial begin
      logic [9*PW-1:0] w;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", ovalid, 0);
      chk("reset_data", odata, 0);
      chk("reset_sat", osat, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Identity kernel after reset.
      for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(10 * k + 10);
      got_q.delete();
      send(w, 2'b01, 4'd0);
      wait_got(1);
      chk("identity_data", got_q[0][PW-1:0], 50);
      chk("identity_sat", got_q[0][PW], 0);
      chk("latency", last_lat, 3);

      // Box kernel with rounding shift.
      for (int k = 0; k < 9; k++) coef_wr(4'(k), 8'd1);
      got_q.delete();
      send(win_all(100), 2'b01, 4'd3);
      send(win_all(255), 2'b01, 4'd3);
      wait_got(2);
      chk("box100_data", got_q[0][PW-1:0], 113);
      chk("box100_sat", got_q[0][PW], 0);
      chk("box255_data", got_q[1][PW-1:0], 255);
      chk("box255_sat", got_q[1][PW], 1);

      // Sobel-X in signed and absolute modes.
      coef_wr(0, 8'd1);  coef_wr(1, 8'd0); coef_wr(2, 8'hFF);
      coef_wr(3, 8'd2);  coef_wr(4, 8'd0); coef_wr(5, 8'hFE);
      coef_wr(6, 8'd1);  coef_wr(7, 8'd0); coef_wr(8, 8'hFF);
      got_q.delete();
      send(win_cols(200, 0, 0), 2'b01, 4'd0);
      send(win_cols(0, 0, 200), 2'b01, 4'd0);
      send(win_cols(0, 0, 200), 2'b10, 4'd0);
      wait_got(3);
      chk("sobel_pos_data", got_q[0][PW-1:0], 255);
      chk("sobel_pos_sat", got_q[0][PW], 1);
      chk("sobel_neg_data", got_q[1][PW-1:0], 0);
      chk("sobel_neg_sat", got_q[1][PW], 1);
      chk("sobel_abs_data", got_q[2][PW-1:0], 255);
      chk("sobel_abs_sat", got_q[2][PW], 1);

      // Centre-only modes ignore the kernel.
      w = win_rand();
      w[4*PW +: PW] = 8'h3C;
      got_q.delete();
      send(w, 2'b11, 4'd5);
      send(w, 2'b00, 4'd0);
      wait_got(2);
      chk("invert_data", got_q[0][PW-1:0], 8'hC3);
      chk("invert_sat", got_q[0][PW], 0);
      chk("bypass_data", got_q[1][PW-1:0], 8'h3C);

      // Six back-to-back windows with a 4-cycle output stall.
      got_q.delete();
      fork
         begin
            for (int i = 0; i < 6; i++) send(win_rand(), 2'($urandom % 4), 4'($urandom % 4));
         end
         begin
            repeat (3) @(posedge clk);
            #1 oready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               if (!pready) saw_stall_ready_low = 1;
               @(posedge clk);
            end
            #1 oready = 1'b1;
         end
      join
      wait_got(6);
      repeat (5) tick();
      chk("stall_total_outputs", got_q.size(), 6);
      chk("stall_ready_low", saw_stall_ready_low, 1);

      // Coefficient write in the same cycle as an accept.
      do_reset();
      w = win_all(0);
      w[4*PW +: PW] = 8'd40;
      got_q.delete();
      pix = w; mode = 2'b01; shift = 4'd0; pvalid = 1'b1;
      we = 1'b1; addr = 4'd4; cdata = 8'd2;
      @(negedge clk);
      chk("same_cycle_ready", pready, 1);
      tick();
      we = 1'b0;
      @(negedge clk);
      tick();
      pvalid = 1'b0;
      wait_got(2);
      chk("old_coef_data", got_q[0][PW-1:0], 40);
      chk("new_coef_data", got_q[1][PW-1:0], 80);

      // Out-of-range address must not alias onto the bank.
      coef_wr(4'd12, 8'd5);
      w = win_all(10);
      w[4*PW +: PW] = 8'd40;
      got_q.delete();
      send(w, 2'b01, 4'd0);
      wait_got(1);
      chk("addr12_ignored", got_q[0][PW-1:0], 80);

      // Asynchronous reset while windows are in flight.
      repeat (3) tick();
      got_q.delete();
      for (int i = 0; i < 3; i++) send(win_rand(), 2'b01, 4'd1);
      chk("pre_reset_valid", ovalid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_valid", ovalid, 0);
      chk("async_reset_data", odata, 0);
      chk("async_reset_sat", osat, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) tick();
      chk("no_output_after_reset", got_q.size(), 0);

      // Randomised traffic, back-pressure and coefficient updates.
      for (int i = 0; i < 1500; i++) begin
         pix    = win_rand();
         pvalid = ($urandom % 4) != 0;
         mode   = 2'($urandom % 4);
         shift  = 4'($urandom % 16);
         oready = ($urandom % 4) != 0;
         we     = ($urandom % 8) == 0;
         addr   = 4'($urandom % 16);
         cdata  = 8'($urandom);
         tick();
      end
      pvalid = 1'b0; we = 1'b0; oready = 1'b1;
      repeat (10) tick();
      chk("drain_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
